// File: rtl/lc3_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg
// Shared definitions for the LC-3 memory subsystem.
//   - sram_state_e             : state encoding of the SRAM access controller
//   - SRAM_WAIT_STATES_DEFAULT : default number of extra strobe cycles
//   - SRAM_DATA_W / SRAM_ADDR_W: SRAM data and address widths
//   - ws_load()                : converts a wait-state count to the 3-bit
//                                ACCESS down-counter load value
// -----------------------------------------------------------------------------
package lc3_pkg;

  localparam int unsigned SRAM_WAIT_STATES_DEFAULT = 1;
  localparam int unsigned SRAM_DATA_W              = 16;
  localparam int unsigned SRAM_ADDR_W              = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RECOVER = 2'd3
  } sram_state_e;

  // The ACCESS phase lasts (load value + 1) cycles, so the counter is
  // loaded with the wait-state count itself. Legal range is 0..7.
  function automatic logic [2:0] ws_load(input int unsigned ws);
    logic [31:0] w_ws;
    w_ws = ws;
    return w_ws[2:0];
  endfunction

endpackage

// File: rtl/tri_buffer_16.sv
// -----------------------------------------------------------------------------
// tri_buffer_16
// 16-bit tri-state buffer for the bidirectional SRAM data bus.
// Ports:
//   i_en    : drive enable (1 = drive io_bus with i_data, 0 = high-Z)
//   i_data  : data to drive onto the bus
//   io_bus  : bidirectional bus pin
//   o_data  : current value seen on the bus (for read capture)
// -----------------------------------------------------------------------------
module tri_buffer_16 (
  input  logic        i_en,
  input  logic [15:0] i_data,
  inout  wire  [15:0] io_bus,
  output logic [15:0] o_data
);

  assign io_bus = i_en ? i_data : 16'bz;
  assign o_data = io_bus;

endmodule

// File: rtl/sram_access_ctrl.sv
// -----------------------------------------------------------------------------
// sram_access_ctrl
// Single-transaction controller for an asynchronous 16-bit SRAM. A request is
// accepted only in IDLE and walks through SETUP -> ACCESS (WAIT_STATES+1
// cycles) -> RECOVER -> IDLE. Every SRAM-facing signal, Done, Busy and the
// bus-drive enable come straight from flops, decoded from the next state, so
// they change only on the clock edge and never glitch.
// Ports:
//   i_clk      : clock, all state changes on the rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_req      : access request (sampled only in IDLE)
//   i_write    : 1 = write, 0 = read (sampled with i_req)
//   i_addr     : word address (sampled with i_req)
//   i_wdata    : write data (sampled with i_req)
//   o_rdata    : data of the last completed read
//   o_done     : one-cycle completion pulse (RECOVER)
//   o_busy     : high whenever the controller is not IDLE
//   o_addr     : SRAM address, held from SETUP through RECOVER and in IDLE
//   o_ce_n, o_ub_n, o_lb_n, o_oe_n, o_we_n : active-low SRAM strobes
//   io_mem_bus : SRAM data bus, driven only during write ACCESS/RECOVER
// -----------------------------------------------------------------------------
module sram_access_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned WAIT_STATES = SRAM_WAIT_STATES_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_done,
  output logic        o_busy,
  output logic [15:0] o_addr,
  output logic        o_ce_n,
  output logic        o_ub_n,
  output logic        o_lb_n,
  output logic        o_oe_n,
  output logic        o_we_n,
  inout  wire  [15:0] io_mem_bus
);

  localparam logic [2:0] WS_LOAD = ws_load(WAIT_STATES);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  sram_state_e r_state;
  logic [2:0]  r_cnt;
  logic        r_write;
  logic [15:0] r_wdata;
  logic [15:0] r_addr;
  logic [15:0] r_rdata;

  // Registered outputs
  logic        r_done;
  logic        r_busy;
  logic        r_ce_n;
  logic        r_byte_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_drive;

  // ---------------------------------------------------------------------------
  // Next-state / next-output signals
  // ---------------------------------------------------------------------------
  sram_state_e w_state_next;
  logic [2:0]  w_cnt_next;
  logic        w_accept;
  logic        w_capture;
  logic        w_write_next;
  logic        w_done_next;
  logic        w_busy_next;
  logic        w_ce_n_next;
  logic        w_oe_n_next;
  logic        w_we_n_next;
  logic        w_drive_next;
  logic [15:0] w_bus_in;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_capture    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_state_next = ST_SETUP;
          w_accept     = 1'b1;
        end
      end
      ST_SETUP: begin
        // Counter is loaded while leaving SETUP so ACCESS starts with the
        // full wait-state count and exits when it reaches zero.
        w_state_next = ST_ACCESS;
        w_cnt_next   = WS_LOAD;
      end
      ST_ACCESS: begin
        if (r_cnt == 3'd0) begin
          w_state_next = ST_RECOVER;
          // Read data is sampled at the edge that ends the OE-low window.
          w_capture    = ~r_write;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      ST_RECOVER: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the *next* state, so that the flops below present the
  // strobes in the same cycle as the state they belong to. The direction
  // used is the one that will be latched after this edge (i_write when a
  // request is being accepted).
  // ---------------------------------------------------------------------------
  always_comb begin
    w_write_next = w_accept ? i_write : r_write;
    w_done_next  = (w_state_next == ST_RECOVER);
    w_busy_next  = (w_state_next != ST_IDLE);
    w_ce_n_next  = (w_state_next == ST_IDLE);
    w_oe_n_next  = ~((w_state_next == ST_ACCESS) && ~w_write_next);
    w_we_n_next  = ~((w_state_next == ST_ACCESS) &&  w_write_next);
    // Write data is held through RECOVER after WE rises.
    w_drive_next = w_write_next &&
                   ((w_state_next == ST_ACCESS) || (w_state_next == ST_RECOVER));
  end

  // ---------------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_write <= 1'b0;
      r_wdata <= 16'h0000;
      r_addr  <= 16'h0000;
      r_rdata <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_write <= i_write;
        r_wdata <= i_wdata;
        r_addr  <= i_addr;
      end
      if (w_capture) begin
        r_rdata <= w_bus_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered strobes and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ce_n   <= 1'b1;
      r_byte_n <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_drive  <= 1'b0;
    end else begin
      r_done   <= w_done_next;
      r_busy   <= w_busy_next;
      r_ce_n   <= w_ce_n_next;
      // Full-word accesses only: both byte lanes follow chip enable.
      r_byte_n <= w_ce_n_next;
      r_oe_n   <= w_oe_n_next;
      r_we_n   <= w_we_n_next;
      r_drive  <= w_drive_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Data bus
  // ---------------------------------------------------------------------------
  tri_buffer_16 u_bus_buf (
    .i_en   (r_drive),
    .i_data (r_wdata),
    .io_bus (io_mem_bus),
    .o_data (w_bus_in)
  );

  assign o_rdata = r_rdata;
  assign o_done  = r_done;
  assign o_busy  = r_busy;
  assign o_addr  = r_addr;
  assign o_ce_n  = r_ce_n;
  assign o_ub_n  = r_byte_n;
  assign o_lb_n  = r_byte_n;
  assign o_oe_n  = r_oe_n;
  assign o_we_n  = r_we_n;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_access_ctrl
// Scoreboard bench for sram_access_ctrl with a small behavioural SRAM.
// Expected transactions are queued when a request is accepted and compared
// when Done is seen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_access_ctrl;

  localparam int WS = 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        wr    = 1'b0;
  logic [15:0] addr  = 16'h0000;
  logic [15:0] wdata = 16'h0000;

  logic [15:0] rdata;
  logic [15:0] sram_addr;
  logic        done, busy, ce_n, ub_n, lb_n, oe_n, we_n;
  wire  [15:0] mem_bus;

  logic [15:0] sram   [0:255];
  logic [15:0] shadow [0:255];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int oe_cnt   = 0;
  int we_cnt   = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] rdata;
    int          done_cyc;
  } txn_t;

  txn_t        sb[$];
  txn_t        mon_t;
  logic [15:0] exp_rdata = 16'h0000;

  always #5 clk = ~clk;

  sram_access_ctrl #(.WAIT_STATES(WS)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_write    (wr),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .o_done     (done),
    .o_busy     (busy),
    .o_addr     (sram_addr),
    .o_ce_n     (ce_n),
    .o_ub_n     (ub_n),
    .o_lb_n     (lb_n),
    .o_oe_n     (oe_n),
    .o_we_n     (we_n),
    .io_mem_bus (mem_bus)
  );

  function automatic logic [15:0] preload(input int i);
    return (i == 16'h40) ? 16'hBEEF : 16'(i * 7 + 3);
  endfunction

  // Behavioural asynchronous SRAM: drives the bus while CE and OE are low,
  // stores on every rising edge while CE and WE are low.
  assign mem_bus = (!ce_n && !oe_n) ? sram[sram_addr[7:0]] : 16'bz;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) sram[i] <= preload(i);
    end else if (!ce_n && !we_n) begin
      sram[sram_addr[7:0]] <= mem_bus;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Queue the expected outcome of a request that was just accepted.
  task automatic push_exp(input logic w, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.wr   = w;
    t.addr = a;
    t.data = d;
    t.done_cyc = cyc + WS + 2;
    if (w) shadow[a[7:0]] = d;
    else   exp_rdata = shadow[a[7:0]];
    t.rdata = exp_rdata;
    sb.push_back(t);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    push_exp(w, a, d);
    @(negedge clk);
    req = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Monitor: strobe exclusivity every cycle, strobe-window lengths and
  // results at every Done.
  always @(negedge clk) begin
    if (rst_n) begin
      check("oe_we_excl", 32'(oe_n | we_n), 32'd1);
      if (!oe_n) oe_cnt++;
      if (!we_n) we_cnt++;
      if (!we_n && sb.size() > 0) check("wr_bus_access", 32'(mem_bus), 32'(sb[0].data));
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_t = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(mon_t.done_cyc));
          check("rdata", 32'(rdata), 32'(mon_t.rdata));
          check("addr", 32'(sram_addr), 32'(mon_t.addr));
          check("oe_low_cycles", 32'(oe_cnt), mon_t.wr ? 32'd0 : 32'(WS + 1));
          check("we_low_cycles", 32'(we_cnt), mon_t.wr ? 32'(WS + 1) : 32'd0);
          check("ce_in_recover", 32'(ce_n), 32'd0);
          if (mon_t.wr) begin
            check("wr_bus_recover", 32'(mem_bus), 32'(mon_t.data));
            check("sram_stored", 32'(sram[mon_t.addr[7:0]]), 32'(mon_t.data));
          end
          $display("txn %s addr=%04h data=%04h rdata=%04h cyc=%0d",
                   mon_t.wr ? "WR" : "RD", mon_t.addr, mon_t.data, rdata, cyc);
        end
        oe_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = preload(i);

    // Reset state
    #12;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_addr",  32'(sram_addr), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_strobes", 32'({ce_n, ub_n, lb_n, oe_n, we_n}), 32'h1F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic read, write, read-back
    access(1'b0, 16'h0040, 16'h0000);
    wait_idle("idle_rd40");
    access(1'b1, 16'h0041, 16'h1234);
    wait_idle("idle_wr41");
    access(1'b0, 16'h0041, 16'h0000);
    wait_idle("idle_rd41");

    // Req held high: one acceptance every WS+4 cycles, address changed
    // while busy must not leak into the running access.
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 16'h0010;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      push_exp(1'b0, addr, 16'h0000);
      addr = 16'h0011 + 16'(k);
      repeat (WS + 3) @(posedge clk);
    end
    #1 req = 1'b0;
    wait_idle("idle_stream");

    // Req pulsed in SETUP, ACCESS and RECOVER must be ignored.
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 16'h0020;
    @(posedge clk); #1;
    push_exp(1'b0, 16'h0020, 16'h0000);
    for (int i = 0; i < WS + 3; i++) begin
      @(negedge clk);
      req = 1'b1; wr = 1'b1; addr = 16'h0030; wdata = 16'hDEAD;
    end
    @(negedge clk);
    req = 1'b0;
    wait_idle("idle_pulse");

    // Reset during write ACCESS: abort, no Done, no SRAM update.
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 16'h0041; wdata = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("we_low_before_abort", 32'(we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_we",    32'(we_n),  32'd1);
    check("abort_ce",    32'(ce_n),  32'd1);
    check("abort_oe",    32'(oe_n),  32'd1);
    check("abort_done",  32'(done),  32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    oe_cnt = 0;
    we_cnt = 0;
    exp_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 16'h0041, 16'h0000);
    wait_idle("idle_after_abort");
    access(1'b0, 16'h0030, 16'h0000);
    wait_idle("idle_rd30");

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 1, extra read/write strobe cycles (legal 0..7).
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Req  input  1  access request, sampled only in IDLE.
REQ-005 Write  input  1  1 = write, 0 = read; sampled with Req.
REQ-006 Addr  input  16  word address (from MAR), sampled with Req.
REQ-007 Wdata  input  16  write data (from MDR), sampled with Req.
REQ-008 Rdata  output  16  last completed read data.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 Busy  output  1  high whenever state is not IDLE.
REQ-011 ADDR  output  16  SRAM address.
REQ-012 CE, UB, LB, OE, WE  output  1 each  SRAM strobes, active-low.
REQ-013 Mem_Bus  inout  16  SRAM data bus; driven only during write phases, high-Z otherwise.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, ACCESS, RECOVER.
REQ-015 IDLE: Req=1 at rising edge SHALL latch Write/Addr/Wdata and go to SETUP; Req=0 stays IDLE.
REQ-016 SETUP: one cycle; CE=UB=LB=0, ADDR=latched Addr, OE=WE=1; then ACCESS.
REQ-017 ACCESS: exactly WAIT_STATES+1 cycles, tracked by 3-bit down-counter loaded in SETUP; then RECOVER.
REQ-018 ACCESS read: OE=0, WE=1, Mem_Bus high-Z; Rdata SHALL load Mem_Bus at the edge leaving ACCESS.
REQ-019 ACCESS write: WE=0, OE=1, Mem_Bus driven with latched Wdata.
REQ-020 RECOVER: one cycle; OE=WE=1, CE=0, Mem_Bus still driven on writes (data hold); Done=1; then IDLE.
REQ-021 Latency: Done SHALL be high in the cycle beginning WAIT_STATES+2 edges after the accepting edge.
REQ-022 Req while Busy=1 (including RECOVER) SHALL be ignored, not queued; minimum request spacing is WAIT_STATES+4 cycles.
REQ-023 Writes SHALL NOT change Rdata; Rdata holds until next completed read.
REQ-024 ADDR SHALL remain stable from SETUP through RECOVER; ADDR holds last value in IDLE.
REQ-025 All strobes, ADDR, Done, Busy and the bus-drive enable SHALL be registered (glitch-free), never combinational decode.
REQ-026 OE=0 and WE=0 SHALL never occur in the same cycle; bus drive SHALL never coincide with OE=0.

Reset
REQ-027 Reset=0 SHALL asynchronously force IDLE, counter=0, ADDR=0, Rdata=0, Done=0, Busy=0, CE=UB=LB=OE=WE=1, Mem_Bus high-Z.
REQ-028 Reset mid-access SHALL abort without Done; Rdata not updated; first Req after release SHALL be serviced normally.

Structure
REQ-029 State enum and WAIT_STATES default SHALL live in shared package lc3_pkg.
REQ-030 Mem_Bus drive SHALL use one tri_buffer_16 instance enabled by the registered write-drive flag.

Verification
REQ-031 W=1 read: Addr=16'h0040, SRAM model returns 16'hBEEF -> OE low 2 cycles, Done at edge+3, Rdata=16'hBEEF.
REQ-032 W=1 write: Addr=16'h0041, Wdata=16'h1234 -> WE low 2 cycles, Mem_Bus=16'h1234 through RECOVER, model stores 16'h1234, Rdata unchanged.
REQ-033 Req held high continuously, W=0 -> accepts every 4 cycles, exactly one Done per access.
REQ-034 Req pulsed in SETUP/ACCESS/RECOVER -> ignored, no extra Done.
REQ-035 Reset=0 during write ACCESS -> WE=1, CE=1, Mem_Bus high-Z immediately, no Done; next read of 16'h0041 completes normally.
REQ-036 Assertion every cycle: never (OE=0 and WE=0), never (bus driven and OE=0).
